// File: rtl/bus_timer.sv
// ---------------------------------------------------------------------------
// bus_timer
//
// Memory-mapped 16-bit down-counter timer on the 65C02 CPU bus. An 8-byte
// register window at BASE (AD[2:0] selects the register) is decoded from
// AD/WE. Writes complete at the sampling edge. Reads are stretched by WAIT
// wait states, during which RDY is held low.
//
// Register map (offset):
//   0 CNT_L  read live counter[7:0]      write reload[7:0]
//   1 CNT_H  read counter[15:8]          write reload[15:8], counter <= reload
//   2 CTRL   bit0 EN, bit1 AUTO, bit2 IE (bits 7:3 read 0)
//   3 STAT   bit0 UF, write 1 to clear
//   4 PRE    prescaler reload, counter steps every PRE+1 clocks
//   5-7      read 8'h00, writes ignored
//
// Parameters:
//   BASE       base address of the register window (bits [2:0] ignored)
//   WAIT       read wait states, 0..15
//
// Ports:
//   clk        CPU clock
//   RST_N      asynchronous active-low reset
//   AD         CPU address bus
//   WE         CPU write enable
//   DO         CPU write data
//   DATA       read data for the system DI mux, valid while DATA_EN=1
//   DATA_EN    this block drives DI in this cycle
//   RDY        registered ready to the CPU (ANDed externally)
//   IRQ        registered level interrupt request (UF & IE)
//   dbg_state  current access state (IDLE=0, WAITING=1, DATA=2)
//
// Bus handshake: the bus is sampled only at edges where RDY=1. A sampled
// read hit either drops RDY (WAIT>0) or goes straight to DATA (WAIT=0).
// While RDY=0 the CPU holds its next address, and AD/WE are ignored.
//
// Build option: define BUS_TIMER_SNAPSHOT_EN to add a snapshot register.
// It captures counter[15:8] when CNT_L is read, and CNT_H reads return the
// captured byte, so a CNT_L then CNT_H read pair is a coherent 16-bit value.
// Without the macro, CNT_H returns live counter[15:8].
// ---------------------------------------------------------------------------
module bus_timer #(
    parameter logic [15:0] BASE = 16'hFE80,
    parameter int unsigned WAIT = 1
) (
    input  logic        clk,
    input  logic        RST_N,
    input  logic [15:0] AD,
    input  logic        WE,
    input  logic [7:0]  DO,
    output logic [7:0]  DATA,
    output logic        DATA_EN,
    output logic        RDY,
    output logic        IRQ,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAITING = 2'd1,
        ST_DATA    = 2'd2
    } state_t;

    // The wait counter counts WAIT-1 down to 0, so WAITING lasts WAIT cycles.
    localparam logic [3:0] WAIT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    // Access state machine
    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [2:0]  off_q, off_d;
    logic        rdy_q, rdy_d;
    logic        data_en_q, data_en_d;
    logic [7:0]  data_q, data_d;

    // Timer registers
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] reload_q, reload_d;
    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        ie_q, ie_d;
    logic        uf_q, uf_d;
    logic [7:0]  pre_q, pre_d;
    logic [7:0]  presc_q, presc_d;
    logic        irq_q, irq_d;

    // Decode and read path
    logic        hit;
    logic        wr_hit;
    logic        rd_hit;
    logic        wr_cnt_h;
    logic        tick;
    logic        uf_set;
    logic        uf_clr;
    logic        enter_data;
    logic [2:0]  rd_off;
    logic [7:0]  rd_val;
    logic [7:0]  cnt_h_rd;

    assign hit      = (AD[15:3] == BASE[15:3]);
    assign wr_hit   = rdy_q & hit & WE;
    assign rd_hit   = rdy_q & hit & ~WE;
    assign wr_cnt_h = wr_hit & (AD[2:0] == 3'd1);
    assign tick     = en_q & (presc_q == 8'd0);

`ifdef BUS_TIMER_SNAPSHOT_EN
    logic [7:0] snap_q, snap_d;

    always_comb begin
        snap_d = snap_q;
        if (enter_data && (rd_off == 3'd0)) begin
            snap_d = cnt_q[15:8];
        end
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            snap_q <= 8'h00;
        end else begin
            snap_q <= snap_d;
        end
    end

    assign cnt_h_rd = snap_q;
`else
    assign cnt_h_rd = cnt_q[15:8];
`endif

    always_comb begin
        rd_val = 8'h00;
        case (rd_off)
            3'd0:    rd_val = cnt_q[7:0];
            3'd1:    rd_val = cnt_h_rd;
            3'd2:    rd_val = {5'b00000, ie_q, auto_q, en_q};
            3'd3:    rd_val = {7'b0000000, uf_q};
            3'd4:    rd_val = pre_q;
            default: rd_val = 8'h00;
        endcase
    end

    // Access FSM: next state and registered bus outputs
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        off_d      = off_q;
        enter_data = 1'b0;
        rd_off     = off_q;
        case (state_q)
            ST_WAITING: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d    = ST_DATA;
                    enter_data = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            default: begin
                // IDLE and DATA both sample the bus, so a hit in DATA
                // starts the next access back to back.
                state_d = ST_IDLE;
                if (rd_hit) begin
                    off_d = AD[2:0];
                    if (WAIT == 0) begin
                        state_d    = ST_DATA;
                        enter_data = 1'b1;
                        rd_off     = AD[2:0];
                    end else begin
                        state_d    = ST_WAITING;
                        wait_cnt_d = WAIT_INIT;
                    end
                end
            end
        endcase
        rdy_d     = (state_d != ST_WAITING);
        data_en_d = (state_d == ST_DATA);
        // DATA holds the value captured on entry and is not re-sampled.
        data_d    = enter_data ? rd_val : 8'h00;
    end

    // Timer datapath
    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        en_d     = en_q;
        auto_d   = auto_q;
        ie_d     = ie_q;
        pre_d    = pre_q;
        presc_d  = presc_q;
        uf_set   = 1'b0;
        uf_clr   = 1'b0;

        if (en_q) begin
            presc_d = tick ? pre_q : (presc_q - 8'd1);
        end

        // A CNT_H write in the same cycle overrides the tick completely.
        if (tick && !wr_cnt_h) begin
            if (cnt_q != 16'h0000) begin
                cnt_d = cnt_q - 16'h0001;
            end else begin
                uf_set = 1'b1;
                if (auto_q) begin
                    cnt_d = reload_q;
                end else begin
                    en_d = 1'b0;
                end
            end
        end

        if (wr_hit) begin
            case (AD[2:0])
                3'd0: reload_d[7:0] = DO;
                3'd1: begin
                    reload_d[15:8] = DO;
                    cnt_d          = {DO, reload_q[7:0]};
                    presc_d        = pre_q;
                end
                3'd2: begin
                    en_d   = DO[0];
                    auto_d = DO[1];
                    ie_d   = DO[2];
                    if (DO[0]) begin
                        presc_d = pre_q;
                    end
                end
                3'd3: uf_clr = DO[0];
                3'd4: pre_d = DO;
                default: ;
            endcase
        end

        // A coincident underflow beats a software clear.
        if (uf_set) begin
            uf_d = 1'b1;
        end else if (uf_clr) begin
            uf_d = 1'b0;
        end else begin
            uf_d = uf_q;
        end

        irq_d = uf_q & ie_q;
    end

    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            off_q      <= 3'd0;
            rdy_q      <= 1'b1;
            data_en_q  <= 1'b0;
            data_q     <= 8'h00;
            cnt_q      <= 16'h0000;
            reload_q   <= 16'hFFFF;
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            ie_q       <= 1'b0;
            uf_q       <= 1'b0;
            pre_q      <= 8'h00;
            presc_q    <= 8'h00;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            off_q      <= off_d;
            rdy_q      <= rdy_d;
            data_en_q  <= data_en_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            reload_q   <= reload_d;
            en_q       <= en_d;
            auto_q     <= auto_d;
            ie_q       <= ie_d;
            uf_q       <= uf_d;
            pre_q      <= pre_d;
            presc_q    <= presc_d;
            irq_q      <= irq_d;
        end
    end

    assign DATA      = data_q;
    assign DATA_EN   = data_en_q;
    assign RDY       = rdy_q;
    assign IRQ       = irq_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_timer.sv
// ---------------------------------------------------------------------------
// tb_bus_timer
//
// Two instances share clock and reset: u_fast (WAIT=0) runs the timer
// function through a table of bus cycles, and u_slow (WAIT=2) covers the
// wait-state, stall and mid-wait reset sequences. Read data is checked
// through one expected queue per instance.
// ---------------------------------------------------------------------------
module tb_bus_timer;

    localparam logic [15:0] BASE_ADDR = 16'hFE80;
    localparam logic [15:0] IDLE_AD   = 16'h0000;
    localparam logic        RD        = 1'b0;
    localparam logic        WR        = 1'b1;

`ifdef BUS_TIMER_SNAPSHOT_EN
    localparam logic [7:0] SNAP_A = 8'h01;
    localparam logic [7:0] SNAP_B = 8'h02;
`else
    localparam logic [7:0] SNAP_A = 8'h00;
    localparam logic [7:0] SNAP_B = 8'h01;
`endif

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [15:0] f_ad,  s_ad;
    logic        f_we,  s_we;
    logic [7:0]  f_do,  s_do;
    logic [7:0]  f_data, s_data;
    logic        f_data_en, s_data_en;
    logic        f_rdy, s_rdy;
    logic        f_irq, s_irq;
    logic [1:0]  f_dbg, s_dbg;

    bus_timer #(.BASE(BASE_ADDR), .WAIT(0)) u_fast (
        .clk(clk), .RST_N(rst_n), .AD(f_ad), .WE(f_we), .DO(f_do),
        .DATA(f_data), .DATA_EN(f_data_en), .RDY(f_rdy), .IRQ(f_irq),
        .dbg_state(f_dbg)
    );

    bus_timer #(.BASE(BASE_ADDR), .WAIT(2)) u_slow (
        .clk(clk), .RST_N(rst_n), .AD(s_ad), .WE(s_we), .DO(s_do),
        .DATA(s_data), .DATA_EN(s_data_en), .RDY(s_rdy), .IRQ(s_irq),
        .dbg_state(s_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_f[$];
    logic [7:0] exp_s[$];

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, required %02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, required %0b", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name, input logic [7:0] act, inout logic [7:0] q[$]);
        logic [7:0] e;
        if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_unexpected: got read data %02h, required no read", name, act);
        end else begin
            e = q.pop_front();
            check8(name, act, e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && f_data_en) pop_check("fast_rd", f_data, exp_f);
        if (rst_n && s_data_en) pop_check("slow_rd", s_data, exp_s);
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic       we;
        logic [2:0] off;
        logic [7:0] wdata;
        logic [7:0] exp_data;
        logic       chk_irq;
        logic       exp_irq;
    } vec_t;

    localparam int NV = 63;
    vec_t vecs[NV];

    // irq: -1 = no check, 0/1 = IRQ value expected during that bus cycle
    function automatic vec_t mk(input logic we, input logic [2:0] off,
                                input logic [7:0] d, input int irq);
        vec_t v;
        v.we       = we;
        v.off      = off;
        v.wdata    = we ? d : 8'h00;
        v.exp_data = we ? 8'h00 : d;
        v.chk_irq  = (irq >= 0);
        v.exp_irq  = (irq == 1);
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic f_idle();
        f_ad = IDLE_AD; f_we = 1'b0; f_do = 8'h00;
    endtask

    task automatic s_idle();
        s_ad = IDLE_AD; s_we = 1'b0; s_do = 8'h00;
    endtask

    task automatic f_read(input logic [2:0] off, input logic [7:0] exp);
        @(posedge clk); #1;
        f_ad = {BASE_ADDR[15:3], off}; f_we = 1'b0;
        exp_f.push_back(exp);
        @(posedge clk); #1;
        f_idle();
    endtask

    task automatic s_write(input logic [2:0] off, input logic [7:0] d);
        @(posedge clk); #1;
        s_ad = {BASE_ADDR[15:3], off}; s_we = 1'b1; s_do = d;
        @(posedge clk); #1;
        s_idle();
    endtask

    task automatic s_read(input logic [2:0] off, input logic [7:0] exp);
        logic got;
        got = 1'b0;
        @(posedge clk); #1;
        s_ad = {BASE_ADDR[15:3], off}; s_we = 1'b0;
        exp_s.push_back(exp);
        @(posedge clk); #1;
        s_idle();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (s_data_en) begin
                got = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL slow_rd_timeout: got no DATA_EN in 20 cycles, required one");
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test by 200000, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        f_idle();
        s_idle();

        vecs[0]  = mk(RD, 3'd0, 8'h00, -1);
        vecs[1]  = mk(RD, 3'd1, 8'h00, -1);
        vecs[2]  = mk(RD, 3'd2, 8'h00, -1);
        vecs[3]  = mk(RD, 3'd3, 8'h00, -1);
        vecs[4]  = mk(RD, 3'd4, 8'h00, -1);
        // auto-reload: PRE=0, reload 0x0003, CTRL=EN|AUTO|IE
        vecs[5]  = mk(WR, 3'd4, 8'h00, -1);
        vecs[6]  = mk(WR, 3'd0, 8'h03, -1);
        vecs[7]  = mk(WR, 3'd1, 8'h00, -1);
        vecs[8]  = mk(WR, 3'd2, 8'h07, -1);
        vecs[9]  = mk(RD, 3'd0, 8'h03, -1);
        vecs[10] = mk(RD, 3'd0, 8'h02, -1);
        vecs[11] = mk(RD, 3'd0, 8'h01, -1);
        vecs[12] = mk(RD, 3'd0, 8'h00, -1);
        vecs[13] = mk(RD, 3'd0, 8'h03, 0);
        vecs[14] = mk(RD, 3'd3, 8'h01, 1);
        vecs[15] = mk(RD, 3'd2, 8'h07, -1);
        // unused offsets
        vecs[16] = mk(WR, 3'd5, 8'hFF, -1);
        vecs[17] = mk(RD, 3'd5, 8'h00, -1);
        vecs[18] = mk(RD, 3'd7, 8'h00, -1);
        // stop (keep IE), clear UF
        vecs[19] = mk(WR, 3'd2, 8'h04, -1);
        vecs[20] = mk(WR, 3'd3, 8'h01, 1);
        vecs[21] = mk(RD, 3'd3, 8'h00, 1);
        vecs[22] = mk(RD, 3'd0, 8'h00, 0);
        // one-shot, reload 0x0001
        vecs[23] = mk(WR, 3'd0, 8'h01, -1);
        vecs[24] = mk(WR, 3'd1, 8'h00, -1);
        vecs[25] = mk(WR, 3'd2, 8'h05, -1);
        vecs[26] = mk(RD, 3'd0, 8'h01, -1);
        vecs[27] = mk(RD, 3'd0, 8'h00, -1);
        vecs[28] = mk(RD, 3'd2, 8'h04, 0);
        vecs[29] = mk(RD, 3'd1, 8'h00, 1);
        vecs[30] = mk(WR, 3'd3, 8'h01, 1);
        vecs[31] = mk(RD, 3'd0, 8'h00, 1);
        vecs[32] = mk(RD, 3'd3, 8'h00, 0);
        // underflow coincident with STAT clear
        vecs[33] = mk(WR, 3'd1, 8'h00, -1);
        vecs[34] = mk(WR, 3'd2, 8'h05, -1);
        vecs[35] = mk(RD, 3'd0, 8'h01, -1);
        vecs[36] = mk(WR, 3'd3, 8'h01, -1);
        vecs[37] = mk(RD, 3'd3, 8'h01, 0);
        vecs[38] = mk(RD, 3'd3, 8'h01, 1);
        vecs[39] = mk(RD, 3'd2, 8'h04, 1);
        // snapshot: counter 0x0100 decrementing
        vecs[40] = mk(WR, 3'd3, 8'h01, -1);
        vecs[41] = mk(WR, 3'd0, 8'h00, -1);
        vecs[42] = mk(WR, 3'd1, 8'h01, -1);
        vecs[43] = mk(WR, 3'd2, 8'h01, -1);
        vecs[44] = mk(RD, 3'd0, 8'h00, -1);
        vecs[45] = mk(RD, 3'd1, SNAP_A, -1);
        vecs[46] = mk(WR, 3'd2, 8'h00, -1);
        // CNT_H write on a tick cycle: write wins
        vecs[47] = mk(WR, 3'd2, 8'h01, -1);
        vecs[48] = mk(WR, 3'd1, 8'h02, -1);
        vecs[49] = mk(RD, 3'd0, 8'h00, -1);
        vecs[50] = mk(RD, 3'd1, SNAP_B, -1);
        vecs[51] = mk(WR, 3'd2, 8'h00, -1);
        // prescaler PRE=1: one step every 2 clocks
        vecs[52] = mk(WR, 3'd4, 8'h01, -1);
        vecs[53] = mk(WR, 3'd0, 8'h05, -1);
        vecs[54] = mk(WR, 3'd1, 8'h00, -1);
        vecs[55] = mk(WR, 3'd2, 8'h01, -1);
        vecs[56] = mk(RD, 3'd0, 8'h05, -1);
        vecs[57] = mk(RD, 3'd0, 8'h05, -1);
        vecs[58] = mk(RD, 3'd0, 8'h04, -1);
        vecs[59] = mk(RD, 3'd0, 8'h04, -1);
        vecs[60] = mk(RD, 3'd0, 8'h03, -1);
        vecs[61] = mk(WR, 3'd2, 8'h00, -1);
        vecs[62] = mk(RD, 3'd4, 8'h01, -1);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check8("rst_fast_data", f_data, 8'h00);
        check1("rst_fast_data_en", f_data_en, 1'b0);
        check1("rst_fast_rdy", f_rdy, 1'b1);
        check1("rst_fast_irq", f_irq, 1'b0);
        check8("rst_slow_data", s_data, 8'h00);
        check1("rst_slow_data_en", s_data_en, 1'b0);
        check1("rst_slow_rdy", s_rdy, 1'b1);
        check1("rst_slow_irq", s_irq, 1'b0);
        rst_n = 1'b1;

        // table-driven run on the zero-wait instance
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            f_ad = {BASE_ADDR[15:3], vecs[i].off};
            f_we = vecs[i].we;
            f_do = vecs[i].wdata;
            if (!vecs[i].we) exp_f.push_back(vecs[i].exp_data);
            @(negedge clk);
            if (vecs[i].chk_irq) check1($sformatf("irq_row%0d", i), f_irq, vecs[i].exp_irq);
        end
        @(posedge clk); #1;
        f_idle();

        // WAIT=2: read STAT, write attempt held on the bus during the stall
        @(posedge clk); #1;
        s_ad = {BASE_ADDR[15:3], 3'd3}; s_we = 1'b0;
        exp_s.push_back(8'h00);
        @(negedge clk);
        check1("wait_rdy_n", s_rdy, 1'b1);
        @(posedge clk); #1;
        s_ad = {BASE_ADDR[15:3], 3'd4}; s_we = 1'b1; s_do = 8'h55;
        @(negedge clk);
        check1("wait_rdy_n1", s_rdy, 1'b0);
        check1("wait_den_n1", s_data_en, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check1("wait_rdy_n2", s_rdy, 1'b0);
        check1("wait_den_n2", s_data_en, 1'b0);
        @(posedge clk); #1;
        s_idle();
        @(negedge clk);
        check1("wait_rdy_n3", s_rdy, 1'b1);
        check1("wait_den_n3", s_data_en, 1'b1);
        check8("wait_data_n3", s_data, 8'h00);
        // the stalled write must not have reached PRE
        s_read(3'd4, 8'h00);

        // program the slow instance, then reset it in the middle of a wait
        s_write(3'd4, 8'h12);
        s_write(3'd2, 8'h06);
        s_read(3'd2, 8'h06);
        s_read(3'd4, 8'h12);
        @(posedge clk); #1;
        s_ad = {BASE_ADDR[15:3], 3'd4}; s_we = 1'b0;
        exp_s.push_back(8'h12);
        @(posedge clk); #1;
        s_idle();
        @(negedge clk);
        check1("midwait_rdy_low", s_rdy, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check1("midwait_rst_rdy", s_rdy, 1'b1);
        check1("midwait_rst_den", s_data_en, 1'b0);
        check8("midwait_rst_data", s_data, 8'h00);
        check1("midwait_rst_irq", s_irq, 1'b0);
        exp_s.delete();
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // registers back at reset values, reads serviced normally
        s_read(3'd4, 8'h00);
        s_read(3'd2, 8'h00);
        s_read(3'd3, 8'h00);
        f_read(3'd0, 8'h00);
        f_read(3'd4, 8'h00);
        f_read(3'd2, 8'h00);

        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_f.size() != 0 || exp_s.size() != 0) begin
            n_fail++;
            $display("FAIL pending_reads: got %0d fast and %0d slow outstanding, required 0",
                     exp_f.size(), exp_s.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
